// File: rtl/matrix_gen_engine_pkg.sv
// Shared constants for the matrix generator: error codes, FSM encodings, LFSR seed/taps
// and the value-range mask helper.
package matrix_gen_engine_pkg;

    localparam logic [3:0] ERR_NONE          = 4'd0;
    localparam logic [3:0] ERR_DIM_RANGE     = 4'd1;
    localparam logic [3:0] ERR_COUNT_ZERO    = 4'd2;
    localparam logic [3:0] ERR_ALLOC_TIMEOUT = 4'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_ALLOC  = 3'd2;
    localparam logic [2:0] ST_FILL   = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;
    localparam logic [2:0] ST_NEXT   = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERR    = 3'd7;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Smallest 2^k-1 that is >= v: smear the top set bit downwards.
    function automatic logic [15:0] range_mask(input logic [15:0] v);
        logic [15:0] m;
        m = v;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        return m;
    endfunction

endpackage

// File: rtl/matrix_gen_engine_if.sv
// Bus bundle of the matrix generator: command, allocation, commit, memory write and
// element stream. master = engine side, slave = environment side.
interface matrix_gen_engine_if #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 9,
    parameter int DIM_WIDTH     = 5,
    parameter int COUNT_WIDTH   = 4
);
    // Handshakes: a transfer happens on a clk edge where valid && ready (cmd, elem);
    // alloc_req stays high until alloc_valid; commit_req and mem_wr_en are single-cycle strobes.
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [COUNT_WIDTH-1:0]   cmd_count;
    logic [DIM_WIDTH-1:0]     cmd_m;
    logic [DIM_WIDTH-1:0]     cmd_n;

    logic                     alloc_req;
    logic                     alloc_valid;
    logic [3:0]               alloc_slot;
    logic [ADDR_WIDTH-1:0]    alloc_addr;

    logic                     commit_req;
    logic [3:0]               commit_slot;
    logic [DIM_WIDTH-1:0]     commit_m;
    logic [DIM_WIDTH-1:0]     commit_n;
    logic [ADDR_WIDTH-1:0]    commit_addr;

    logic                     mem_wr_en;
    logic [ADDR_WIDTH-1:0]    mem_wr_addr;
    logic [ELEMENT_WIDTH-1:0] mem_wr_data;

    logic                     elem_valid;
    logic                     elem_ready;
    logic [ELEMENT_WIDTH-1:0] elem_data;
    logic [DIM_WIDTH-1:0]     elem_row;
    logic [DIM_WIDTH-1:0]     elem_col;
    logic                     elem_last;

    modport master (
        input  cmd_valid, cmd_count, cmd_m, cmd_n,
        output cmd_ready,
        output alloc_req,
        input  alloc_valid, alloc_slot, alloc_addr,
        output commit_req, commit_slot, commit_m, commit_n, commit_addr,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output elem_valid, elem_data, elem_row, elem_col, elem_last,
        input  elem_ready
    );

    modport slave (
        output cmd_valid, cmd_count, cmd_m, cmd_n,
        input  cmd_ready,
        input  alloc_req,
        output alloc_valid, alloc_slot, alloc_addr,
        input  commit_req, commit_slot, commit_m, commit_n, commit_addr,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  elem_valid, elem_data, elem_row, elem_col, elem_last,
        output elem_ready
    );

endinterface

// File: rtl/matrix_gen_engine_lfsr.sv
// matgen_lfsr: 16-bit Galois LFSR with seed load, step enable and a zero-seed guard.
module matgen_lfsr
    import matrix_gen_engine_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            // An all-zero state would lock the register, so substitute the default.
            state <= (seed == 16'd0) ? LFSR_DEFAULT_SEED : seed;
        end else if (en) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'd0);
        end
    end

endmodule

// File: rtl/matrix_gen_engine.sv
// Matrix generator: per command, allocates a slot, fills it row-major with bounded
// pseudo-random elements and commits it. Define MATGEN_STREAM_EN for the elem_* stream.
module matrix_gen_engine
    import matrix_gen_engine_pkg::*;
#(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 9,
    parameter int DIM_WIDTH     = 5,
    parameter int COUNT_WIDTH   = 4,
    parameter int ALLOC_TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DIM_WIDTH-1:0]     cfg_max_dim,
    input  logic [ELEMENT_WIDTH-1:0] cfg_max_value,
    input  logic [15:0]              seed,
    input  logic                     seed_load,
    input  logic                     abort,
    matrix_gen_engine_if.master      bus,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               error_code,
    output logic [2:0]               dbg_state
);

    localparam int TW = (ALLOC_TIMEOUT > 1) ? $clog2(ALLOC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ALLOC_TIMEOUT - 1);

    logic [2:0]               state;
    logic [COUNT_WIDTH-1:0]   cnt_q;
    logic [DIM_WIDTH-1:0]     m_q, n_q, row_q, col_q;
    logic [3:0]               slot_q;
    logic [ADDR_WIDTH-1:0]    base_q, addr_q;
    logic [TW-1:0]            timer_q;
    logic [3:0]               err_q;
    logic [15:0]              lfsr_q;
    logic [15:0]              mask16;
    logic [ELEMENT_WIDTH-1:0] raw, elem_value;
    logic                     in_fill, stall, produce, at_last;
    logic                     unused_ready;
    logic                     unused_bits;

    assign in_fill = (state == ST_FILL);
    assign produce = in_fill && !abort && !stall;
    assign at_last = (row_q == m_q - DIM_WIDTH'(1)) && (col_q == n_q - DIM_WIDTH'(1));

    matgen_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seed_load && (state == ST_IDLE)),
        .seed  (seed),
        .en    (produce),
        .state (lfsr_q)
    );

    // Fold the masked raw value into [0, cfg_max_value]; raw never exceeds 2*max+1.
    always_comb begin
        mask16 = range_mask(16'(cfg_max_value));
        raw    = lfsr_q[ELEMENT_WIDTH-1:0] & mask16[ELEMENT_WIDTH-1:0];
        if (cfg_max_value == '0) begin
            elem_value = '0;
        end else if (raw > cfg_max_value) begin
            elem_value = raw - cfg_max_value - ELEMENT_WIDTH'(1);
        end else begin
            elem_value = raw;
        end
    end

    assign unused_bits = ^{lfsr_q, mask16};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            n_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            slot_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            timer_q <= '0;
            err_q   <= ERR_NONE;
        end else if (abort && (state != ST_IDLE)) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        cnt_q <= bus.cmd_count;
                        m_q   <= bus.cmd_m;
                        n_q   <= bus.cmd_n;
                        err_q <= ERR_NONE;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if ((m_q == '0) || (n_q == '0) || (m_q > cfg_max_dim) || (n_q > cfg_max_dim)) begin
                        err_q <= ERR_DIM_RANGE;
                        state <= ST_ERR;
                    end else if (cnt_q == '0) begin
                        err_q <= ERR_COUNT_ZERO;
                        state <= ST_ERR;
                    end else begin
                        timer_q <= '0;
                        state   <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    if (bus.alloc_valid) begin
                        slot_q <= bus.alloc_slot;
                        base_q <= bus.alloc_addr;
                        addr_q <= bus.alloc_addr;
                        row_q  <= '0;
                        col_q  <= '0;
                        state  <= ST_FILL;
                    end else if (timer_q == TIMER_LAST) begin
                        err_q <= ERR_ALLOC_TIMEOUT;
                        state <= ST_ERR;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_FILL: begin
                    // Running address equals base + row*n + col, wrapping naturally.
                    if (produce) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (col_q == n_q - DIM_WIDTH'(1)) begin
                            col_q <= '0;
                            row_q <= row_q + DIM_WIDTH'(1);
                        end else begin
                            col_q <= col_q + DIM_WIDTH'(1);
                        end
                        if (at_last) state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: state <= ST_NEXT;
                ST_NEXT: begin
                    cnt_q   <= cnt_q - COUNT_WIDTH'(1);
                    timer_q <= '0;
                    state   <= (cnt_q == COUNT_WIDTH'(1)) ? ST_DONE : ST_ALLOC;
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state == ST_IDLE);
    assign bus.alloc_req   = (state == ST_ALLOC);
    assign bus.commit_req  = (state == ST_COMMIT) && !abort;
    assign bus.commit_slot = bus.commit_req ? slot_q : '0;
    assign bus.commit_m    = bus.commit_req ? m_q : '0;
    assign bus.commit_n    = bus.commit_req ? n_q : '0;
    assign bus.commit_addr = bus.commit_req ? base_q : '0;
    assign bus.mem_wr_en   = produce;
    assign bus.mem_wr_addr = produce ? addr_q : '0;
    assign bus.mem_wr_data = produce ? elem_value : '0;

`ifdef MATGEN_STREAM_EN
    assign stall          = in_fill && !abort && !bus.elem_ready;
    assign bus.elem_valid = in_fill && !abort;
    assign bus.elem_data  = bus.elem_valid ? elem_value : '0;
    assign bus.elem_row   = bus.elem_valid ? row_q : '0;
    assign bus.elem_col   = bus.elem_valid ? col_q : '0;
    assign bus.elem_last  = bus.elem_valid && at_last;
    assign unused_ready   = 1'b0;
`else
    assign stall          = 1'b0;
    assign bus.elem_valid = 1'b0;
    assign bus.elem_data  = '0;
    assign bus.elem_row   = '0;
    assign bus.elem_col   = '0;
    assign bus.elem_last  = 1'b0;
    assign unused_ready   = bus.elem_ready;
`endif

    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign error_code = err_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_matrix_gen_engine.sv
// Self-checking bench for matrix_gen_engine: command table, randomized commands against
// a reference model, plus hand-written timeout, abort, reset and backpressure sequences.
module tb_matrix_gen_engine;
    import matrix_gen_engine_pkg::*;

    localparam int EW = 8;
    localparam int AW = 9;
    localparam int DW = 5;
    localparam int CW = 4;
    localparam int AT = 15;
    localparam int W  = AW + EW;
    localparam int CQW = 4 + DW + DW + AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] cfg_max_dim;
    logic [EW-1:0] cfg_max_value;
    logic [15:0]   seed;
    logic          seed_load;
    logic          abort;
    logic          busy, done;
    logic [3:0]    error_code;
    logic [2:0]    dbg_state;

    matrix_gen_engine_if #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .DIM_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    matrix_gen_engine #(
        .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .DIM_WIDTH(DW),
        .COUNT_WIDTH(CW), .ALLOC_TIMEOUT(AT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_max_dim(cfg_max_dim), .cfg_max_value(cfg_max_value),
        .seed(seed), .seed_load(seed_load), .abort(abort), .bus(bus),
        .busy(busy), .done(done), .error_code(error_code), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    logic [W-1:0]   exp_q[$];
    logic [CQW-1:0] exp_commit_q[$];
    logic [15:0]    model_lfsr;
    int cur_m, cur_n, cur_max, elems_left;
    int n_checks = 0, n_errors = 0;
    int n_writes = 0, n_commits = 0, n_done = 0, n_allocs = 0, n_alloc_req = 0, n_elem_noise = 0;
    bit resp_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: Galois LFSR and value folding derived from the arithmetic rules.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int map_value(input logic [15:0] s, input int maxv);
        int mask;
        int raw;
        mask = 0;
        while (mask < maxv) mask = mask * 2 + 1;
        raw = int'(s) % (1 << EW);
        raw = raw & mask;
        if (maxv == 0) return 0;
        if (raw > maxv) return raw - maxv - 1;
        return raw;
    endfunction

    function automatic logic [3:0] expect_err(input int cnt, input int m, input int n, input int md);
        if (m == 0 || n == 0 || m > md || n > md) return ERR_DIM_RANGE;
        if (cnt == 0) return ERR_COUNT_ZERO;
        return ERR_NONE;
    endfunction

    // Allocation responder: grants after a random delay and queues the matrix it expects.
    initial begin
        int delay;
        int slot, base, v;
        delay = 0;
        bus.alloc_valid = 1'b0;
        bus.alloc_slot = '0;
        bus.alloc_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.alloc_valid) begin
                bus.alloc_valid = 1'b0;
            end else if (bus.alloc_req && resp_en && rst_n) begin
                if (delay > 0) begin
                    delay--;
                end else begin
                    slot = $urandom_range(0, 15);
                    base = $urandom_range(0, (1 << AW) - 1);
                    bus.alloc_valid = 1'b1;
                    bus.alloc_slot = 4'(slot);
                    bus.alloc_addr = AW'(base);
                    for (int i = 0; i < cur_m * cur_n; i++) begin
                        v = map_value(model_lfsr, cur_max);
                        exp_q.push_back({AW'(base + i), EW'(v)});
                        model_lfsr = lfsr_step(model_lfsr);
                    end
                    exp_commit_q.push_back({4'(slot), DW'(cur_m), DW'(cur_n), AW'(base)});
                    elems_left = cur_m * cur_n;
                    delay = $urandom_range(0, 3);
                end
            end
        end
    end

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [CQW-1:0] c;
        if (rst_n) begin
            if (bus.mem_wr_en) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.mem_wr_addr), 32'(e[W-1:EW]));
                    check("wr_data", 32'(bus.mem_wr_data), 32'(e[EW-1:0]));
                    check("wr_le_max", 32'(bus.mem_wr_data <= cfg_max_value), 1);
`ifdef MATGEN_STREAM_EN
                    check("elem_data", 32'(bus.elem_data), 32'(e[EW-1:0]));
                    check("elem_last", 32'(bus.elem_last), 32'(elems_left == 1));
`endif
                    elems_left--;
                end
            end
`ifndef MATGEN_STREAM_EN
            if (bus.elem_valid || bus.elem_last || bus.elem_data != '0 || bus.elem_row != '0 || bus.elem_col != '0)
                n_elem_noise++;
`endif
            if (bus.commit_req) begin
                n_commits++;
                if (exp_commit_q.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    c = exp_commit_q.pop_front();
                    check("commit_fields", 32'({bus.commit_slot, bus.commit_m, bus.commit_n, bus.commit_addr}), 32'(c));
                end
            end
            if (bus.alloc_req) n_alloc_req++;
            if (bus.alloc_req && bus.alloc_valid) n_allocs++;
            if (done) n_done++;
        end
    end

    // Driver tasks
    task automatic load_seed(input logic [15:0] s);
        @(posedge clk); #1;
        seed = s;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        model_lfsr = (s == 16'd0) ? 16'hACE1 : s;
    endtask

    task automatic start_cmd(input int cnt, input int m, input int n);
        @(posedge clk); #1;
        cur_m = m;
        cur_n = n;
        bus.cmd_valid = 1'b1;
        bus.cmd_count = CW'(cnt);
        bus.cmd_m = DW'(m);
        bus.cmd_n = DW'(n);
        check("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (k == budget) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_first_write(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (bus.mem_wr_en) break;
            @(posedge clk); #1;
        end
        if (k == budget) check("write_timeout", 0, 1);
    endtask

    typedef struct {
        bit          do_seed;
        logic [15:0] sd;
        int          count, m, n, max_dim, max_value;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        int w0, c0, d0, a0, r0;
        logic [3:0] ee;
        cfg_max_dim = DW'(v.max_dim);
        cfg_max_value = EW'(v.max_value);
        cur_max = v.max_value;
        if (v.do_seed) load_seed(v.sd);
        w0 = n_writes; c0 = n_commits; d0 = n_done; a0 = n_allocs; r0 = n_alloc_req;
        ee = expect_err(v.count, v.m, v.n, v.max_dim);
        start_cmd(v.count, v.m, v.n);
        wait_idle(3000);
        @(negedge clk);
        check("error_code", 32'(error_code), 32'(ee));
        if (ee == ERR_NONE) begin
            check("writes", n_writes - w0, v.count * v.m * v.n);
            check("commits", n_commits - c0, v.count);
            check("allocs", n_allocs - a0, v.count);
            check("done_pulses", n_done - d0, 1);
        end else begin
            check("err_no_alloc_req", n_alloc_req - r0, 0);
            check("err_no_writes", n_writes - w0, 0);
            check("err_no_done", n_done - d0, 0);
        end
        check("exp_q_drained", exp_q.size(), 0);
        check("cmd_ready_after", 32'(bus.cmd_ready), 1);
    endtask

    initial begin
        int w0, c0, r0;
        vec_t rv;
        vecs[0] = '{1'b0, 16'h0000, 1, 3, 4, 16, 9};
        vecs[1] = '{1'b1, 16'h0001, 1, 3, 4, 16, 9};
        vecs[2] = '{1'b1, 16'h1234, 3, 2, 2, 16, 15};
        vecs[3] = '{1'b1, 16'h0007, 1, 0, 17, 16, 9};
        vecs[4] = '{1'b1, 16'h0009, 0, 2, 2, 16, 9};
        vecs[5] = '{1'b1, 16'h0000, 2, 3, 3, 16, 0};
        vecs[6] = '{1'b1, 16'hBEEF, 1, 16, 16, 16, 255};
        vecs[7] = '{1'b1, 16'h0042, 1, 5, 4, 4, 9};
        vecs[8] = '{1'b1, 16'h0055, 1, 1, 1, 16, 8};

        // Clock/reset
        rst_n = 1'b0; seed = '0; seed_load = 1'b0; abort = 1'b0;
        cfg_max_dim = DW'(16); cfg_max_value = EW'(9); cur_max = 9;
        bus.cmd_valid = 1'b0; bus.cmd_count = '0; bus.cmd_m = '0; bus.cmd_n = '0;
        bus.elem_ready = 1'b1;
        model_lfsr = 16'hACE1; cur_m = 0; cur_n = 0; elems_left = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_error_code", 32'(error_code), 32'(ERR_NONE));
        check("rst_outputs", 32'({bus.alloc_req, bus.commit_req, bus.mem_wr_en, done, bus.elem_valid}), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        for (int i = 0; i < 10; i++) begin
            rv.do_seed = 1'b1;
            rv.sd = 16'($urandom_range(0, 65535));
            rv.count = $urandom_range(0, 3);
            rv.m = $urandom_range(0, 7);
            rv.n = $urandom_range(1, 7);
            rv.max_dim = $urandom_range(4, 16);
            rv.max_value = $urandom_range(0, 255);
            run_vec(rv);
        end

        // Allocation timeout
        resp_en = 1'b0;
        cfg_max_dim = DW'(16);
        w0 = n_writes; r0 = n_alloc_req;
        start_cmd(1, 1, 1);
        wait_idle(200);
        @(negedge clk);
        check("timeout_code", 32'(error_code), 32'(ERR_ALLOC_TIMEOUT));
        check("timeout_req_cycles", n_alloc_req - r0, AT);
        check("timeout_req_low", 32'(bus.alloc_req), 0);
        check("timeout_no_writes", n_writes - w0, 0);
        resp_en = 1'b1;

        // Abort during the third write of a 4x4 fill
        load_seed(16'h0003);
        cfg_max_value = EW'(9); cur_max = 9;
        w0 = n_writes; c0 = n_commits;
        start_cmd(1, 4, 4);
        wait_first_write(100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_wr_suppressed", 32'(bus.mem_wr_en), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_cmd_ready", 32'(bus.cmd_ready), 1);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_commit", n_commits - c0, 0);
        check("abort_writes", n_writes - w0, 2);
        exp_q.delete();
        exp_commit_q.delete();

        // Reset in the middle of a fill behaves as an abort
        load_seed(16'h0004);
        c0 = n_commits;
        start_cmd(1, 4, 4);
        wait_first_write(100);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_fill_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (4) @(posedge clk);
        #1;
        check("rst_fill_no_commit", n_commits - c0, 0);
        exp_q.delete();
        exp_commit_q.delete();
        model_lfsr = 16'hACE1;

`ifdef MATGEN_STREAM_EN
        // Backpressure: hold elem_ready low for 5 cycles after four elements
        begin
            logic [W-1:0] head;
            load_seed(16'h0001);
            cfg_max_value = EW'(9); cur_max = 9;
            w0 = n_writes;
            start_cmd(1, 3, 4);
            for (int k = 0; k < 200 && (n_writes - w0) < 4; k++) begin
                @(posedge clk); #1;
            end
            bus.elem_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                head = (exp_q.size() > 0) ? exp_q[0] : '0;
                check("stall_valid", 32'(bus.elem_valid), 1);
                check("stall_no_write", 32'(bus.mem_wr_en), 0);
                check("stall_data", 32'(bus.elem_data), 32'(head[EW-1:0]));
                @(posedge clk); #1;
            end
            bus.elem_ready = 1'b1;
            wait_idle(200);
            @(negedge clk);
            check("stall_writes", n_writes - w0, 12);
            check("stall_drained", exp_q.size(), 0);
        end
`else
        check("elem_ports_quiet", n_elem_noise, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
